// File: rtl/mest_pro_pkg.sv
// Shared definitions for the MESTPro instruction sequencer: default field
// widths, the sequencer state encoding and small helper functions.
package mest_pro_pkg;

  localparam int DEF_OPCODE_W    = 8;
  localparam int DEF_OPA_W       = 8;
  localparam int DEF_OPB_W       = 8;
  localparam int DEF_PC_W        = 8;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_MEM_WAIT = 3'd4,
    ST_HALT     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  // Output flags that are a pure function of the state being entered.
  typedef struct packed {
    logic pm_req;
    logic execute;
    logic busy;
    logic halted;
    logic error;
  } ctrl_flags_t;

  // Flag pattern to register alongside a transition into state s.
  function automatic ctrl_flags_t state_flags(input state_t s);
    ctrl_flags_t f;
    f.pm_req  = (s == ST_FETCH);
    f.execute = (s == ST_ISSUE);
    f.busy    = (s == ST_FETCH) || (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_MEM_WAIT);
    f.halted  = (s == ST_HALT);
    f.error   = (s == ST_ERROR);
    return f;
  endfunction

  // Saturating increment for the retired-instruction counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/mest_pro_ret_stack.sv
// Return-address LIFO for call/return. Pointer runs 0..DEPTH; storage is
// written synchronously and is not reset (an empty stack is never read).
module mest_pro_ret_stack
  import mest_pro_pkg::*;
#(
  parameter int DEPTH = DEF_STACK_DEPTH,
  parameter int W     = DEF_PC_W
) (
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] ptr_r;
  logic [PW-1:0] top_s;

  assign top_s    = ptr_r - {{AW{1'b0}}, 1'b1};
  assign pop_data = mem_r[top_s[AW-1:0]];
  assign full     = (ptr_r == PW'(DEPTH));
  assign empty    = (ptr_r == {PW{1'b0}});

  // Stack pointer: cleared on restart, moves one step per push or pop.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr_r <= {PW{1'b0}};
    end else if (clear) begin
      ptr_r <= {PW{1'b0}};
    end else if (push && !full) begin
      ptr_r <= ptr_r + {{AW{1'b0}}, 1'b1};
    end else if (pop && !empty) begin
      ptr_r <= top_s;
    end
  end

  // Entry storage: write the pushed return address at the current pointer.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem_r[ptr_r[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/mest_pro_ctrl.sv
// MESTPro instruction sequencer: fetches from program memory, issues the
// instruction to the execute stage, and applies its control flags to the PC
// and the return-address stack.
module mest_pro_ctrl
  import mest_pro_pkg::*;
#(
  parameter int OPCODE_W    = DEF_OPCODE_W,
  parameter int OPA_W       = DEF_OPA_W,
  parameter int OPB_W       = DEF_OPB_W,
  parameter int PC_W        = DEF_PC_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                          clk,
  input  logic                          i_reset_n,
  input  logic                          i_start,
  output logic                          o_pm_req,
  output logic [PC_W-1:0]               o_pm_addr,
  input  logic                          i_pm_ack,
  input  logic [OPCODE_W+OPA_W+OPB_W-1:0] i_pm_data,
  output logic                          o_execute,
  output logic [OPCODE_W-1:0]           o_op_code,
  output logic [OPA_W-1:0]              o_operand1,
  output logic [OPB_W-1:0]              o_operand2,
  input  logic                          i_exec_done,
  input  logic                          i_jump,
  input  logic                          i_return_pc,
  input  logic                          i_end_of_code,
  input  logic                          i_mm_select,
  input  logic                          i_mem_ready,
  output logic [PC_W-1:0]               o_pc,
  output logic                          o_busy,
  output logic                          o_halted,
  output logic                          o_error,
  output logic [15:0]                   o_instr_count
);

  // Instruction word layout {opcode, opA, opB}, MSB first.
  localparam int OPA_LSB    = OPB_W;
  localparam int OPCODE_LSB = OPA_W + OPB_W;

  state_t              state_r;
  ctrl_flags_t         flags_r;
  logic [PC_W-1:0]     pc_r;
  logic [OPCODE_W-1:0] opcode_r;
  logic [OPA_W-1:0]    opa_r;
  logic [OPB_W-1:0]    opb_r;
  logic [15:0]         count_r;

  logic            start_ok_s;
  logic            done_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [PC_W-1:0] pc_plus1_s;
  logic [PC_W-1:0] pop_data_s;

  assign start_ok_s = i_start && ((state_r == ST_IDLE) || (state_r == ST_HALT) || (state_r == ST_ERROR));
  assign done_s     = (state_r == ST_WAIT) && i_exec_done;
  assign pc_plus1_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
  // Flag priority end_of_code > jump > return means push and pop never coincide.
  assign push_s     = done_s && !i_end_of_code && i_jump && !full_s;
  assign pop_s      = done_s && !i_end_of_code && !i_jump && i_return_pc && !empty_s;

  mest_pro_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .clear     (start_ok_s),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus1_s),
    .pop_data  (pop_data_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Sequencer FSM: state, PC, instruction register, retire counter and flags.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= ST_IDLE;
      flags_r  <= 5'b0;
      pc_r     <= {PC_W{1'b0}};
      opcode_r <= {OPCODE_W{1'b0}};
      opa_r    <= {OPA_W{1'b0}};
      opb_r    <= {OPB_W{1'b0}};
      count_r  <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALT, ST_ERROR: begin
          if (i_start) begin
            state_r <= ST_FETCH;
            flags_r <= state_flags(ST_FETCH);
            pc_r    <= {PC_W{1'b0}};
            count_r <= 16'd0;
          end
        end
        ST_FETCH: begin
          if (i_pm_ack) begin
            opcode_r <= i_pm_data[OPCODE_LSB +: OPCODE_W];
            opa_r    <= i_pm_data[OPA_LSB +: OPA_W];
            opb_r    <= i_pm_data[0 +: OPB_W];
            state_r  <= ST_ISSUE;
            flags_r  <= state_flags(ST_ISSUE);
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
          flags_r <= state_flags(ST_WAIT);
        end
        ST_WAIT: begin
          if (i_exec_done) begin
            if (i_end_of_code) begin
              state_r <= ST_HALT;
              flags_r <= state_flags(ST_HALT);
              count_r <= sat_inc16(count_r);
            end else if (i_jump) begin
              if (full_s) begin
                state_r <= ST_ERROR;
                flags_r <= state_flags(ST_ERROR);
              end else begin
                pc_r    <= opa_r[PC_W-1:0];
                state_r <= ST_FETCH;
                flags_r <= state_flags(ST_FETCH);
                count_r <= sat_inc16(count_r);
              end
            end else if (i_return_pc) begin
              if (empty_s) begin
                state_r <= ST_ERROR;
                flags_r <= state_flags(ST_ERROR);
              end else begin
                pc_r    <= pop_data_s;
                state_r <= ST_FETCH;
                flags_r <= state_flags(ST_FETCH);
                count_r <= sat_inc16(count_r);
              end
            end else if (i_mm_select) begin
              state_r <= ST_MEM_WAIT;
              flags_r <= state_flags(ST_MEM_WAIT);
              count_r <= sat_inc16(count_r);
            end else begin
              pc_r    <= pc_plus1_s;
              state_r <= ST_FETCH;
              flags_r <= state_flags(ST_FETCH);
              count_r <= sat_inc16(count_r);
            end
          end
        end
        ST_MEM_WAIT: begin
          if (i_mem_ready) begin
            pc_r    <= pc_plus1_s;
            state_r <= ST_FETCH;
            flags_r <= state_flags(ST_FETCH);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          flags_r <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  assign o_pm_req      = flags_r.pm_req;
  assign o_execute     = flags_r.execute;
  assign o_busy        = flags_r.busy;
  assign o_halted      = flags_r.halted;
  assign o_error       = flags_r.error;
  assign o_pm_addr     = pc_r;
  assign o_pc          = pc_r;
  assign o_op_code     = opcode_r;
  assign o_operand1    = opa_r;
  assign o_operand2    = opb_r;
  assign o_instr_count = count_r;

endmodule
